ram_access_ctrl: RTL and testbench
==================================

// Module: ram_access_ctrl
// PURPOSE
//  CPU-side sequencer for the 4096x4 nibble data RAM; sits between the execute unit and the RAM.
//  Holds the SRC pointer (chip/reg/char) and the DCL bank, and forms the 12-bit RAM address.
//  Runs WRM/RDM/WRn/RDn as single-request transactions, absorbing the RAM's 1-cycle synchronous read.
// PARAMETERS
//  NUM_BANKS   8   number of DCL banks; bank register is clog2(NUM_BANKS)=3 bits, fixed at 8 in this build
//  RD_LAT      1   RAM read latency in clocks, from the address edge to dataOut valid; only 1 is supported
// PORTS
//  clk         in   1   single system clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  srcLoad     in   1   load srcAddr into SRC pointer
//  srcAddr     in   8   {chip[7:6], reg[5:4], char[3:0]}
//  dclLoad     in   1   load dclBank into bank register
//  dclBank     in   3   RAM bank select
//  reqValid    in   1   request strobe; held until accepted
//  reqReady    out  1   high only in IDLE; accept = reqValid & reqReady at a rising edge
//  reqOp       in   3   000 WRM, 001 RDM, 010 WRS (status write), 011 RDS (status read), 100 WMP
//  reqIdx      in   2   status character index for WRS/RDS
//  reqData     in   4   write nibble
//  rspValid    out  1   1-cycle pulse; read data valid on rspData
//  rspData     out  4   read nibble, held until the next read completes
//  ramWe       out  1   to RAM write enable
//  ramRe       out  1   to RAM read enable
//  ramAddr     out  12  to RAM address
//  ramDataIn   out  4   to RAM write data
//  ramDataOut  in   4   from RAM read data (synchronous)
// BEHAVIOUR
//  Clock and reset: one clock; reset is asynchronous and active-high.
//  Reset values: all outputs 0 except reqReady=1; SRC=0, bank=0, state IDLE.
//  Address map: main chars {1'b0, bank, chip, reg, char}; status chars {1'b1, bank, chip, reg, 2'b00, idx}.
//  Address capture: the address is formed from the pre-edge SRC/bank values at accept and held in an address register.
//   srcLoad/dclLoad in the accept cycle or later never alter an in-flight access; they update for the next request.
//  States: IDLE -> WR (WRM/WRS) | RD_ISS (RDM/RDS) | DONE (WMP or illegal op).
//  WR: ramWe=1, ramAddr/ramDataIn valid for exactly 1 cycle -> IDLE. No rspValid.
//  RD_ISS: ramRe=1, ramAddr valid for 1 cycle -> RD_CAP.
//  RD_CAP: at the end-of-cycle edge rspData<=ramDataOut and rspValid=1 for the following cycle -> IDLE.
//  Read latency: accept at edge T, ramRe in cycle T..T+1, rspValid high in cycle T+2..T+3.
//   The next accept is possible at edge T+3; reads are back-to-back every 3 clocks.
//  Writes: accept at edge T -> ramWe in cycle T..T+1; the next accept is possible at edge T+2.
//  Outputs: ramWe, ramRe, ramAddr and ramDataIn are registered. ramWe and ramRe are never both 1.
//   ramAddr and ramDataIn return to 0 in IDLE.
//  DONE: 1 cycle, no RAM access, -> IDLE. Illegal ops 101-111 are accepted and dropped.
//  Reset mid-operation: aborts immediately, with no rspValid or ramWe afterwards. RAM contents are not touched.
//  reqValid while not ready: ignored. A request must be held until accepted.
// CONFIGURATION
//  RAM_OUTPORT_EN defined:
//   adds port outPort out 16, reset 0: four 4-bit chip output ports {chip3..chip0} of the current bank only.
//   WMP (100) writes reqData into outPort[chip*4 +: 4] at the DONE-cycle edge.
//   A dclLoad switches which bank's port set is visible; storage is 8 banks x 4 chips.
//  RAM_OUTPORT_EN undefined:
//   no outPort port and no port storage; WMP behaves as an illegal op (accept, drop, no side effect).
// TESTING
//  1 Reset values: rst pulse -> reqReady=1, rspValid=0, ramWe=0, ramRe=0, ramAddr=0.
//  2 Write then read main char: dcl=5, src=8'hA7, WRM data=4'hC -> ramWe 1 cycle, ramAddr=12'h5A7.
//    Then RDM -> rspValid 2 cycles after accept, rspData=4'hC.
//  3 Status char: dcl=2, src=8'h3F, WRS idx=2 data=9 -> ramAddr=12'hA32. RDS idx=2 -> rspData=9.
//  4 Pointer change in flight: RDM accepted with src=8'h10, srcLoad 8'h20 in the same cycle
//    -> ramAddr uses char 0x10; the next RDM uses 0x20.
//  5 Abort: rst asserted in RD_ISS -> no rspValid; the following RDM returns stored data intact.
//  6 RAM_OUTPORT_EN: dcl=1, src chip=2, WMP data=4'h6 -> outPort[11:8]=6, no ramWe. dcl=0 -> outPort=0.
//    Without the macro: WMP -> no ramWe, no ramRe, no rspValid.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: CPU-side sequencer for the 4096x4 nibble data RAM.
// Holds the SRC pointer and DCL bank, forms the 12-bit RAM address and runs
// WRM/RDM/WRS/RDS one request at a time, absorbing the RAM's 1-cycle read.
// Optional feature macro: RAM_OUTPORT_EN adds the per-bank chip output ports
// (outPort) written by WMP; without it WMP is accepted and dropped.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | ready for a request, RAM outputs parked at 0
// S_WR    | ramWe high for one cycle with address/data
// S_RD_ISS| ramRe high for one cycle with address
// S_RD_CAP| RAM data valid this cycle, captured into rspData at the edge
// S_DONE  | one dead cycle for WMP / illegal ops, no RAM access
module ram_access_ctrl #(
  parameter int NUM_BANKS = 8,
  parameter int RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        srcLoad,
  input  logic [7:0]  srcAddr,
  input  logic        dclLoad,
  input  logic [2:0]  dclBank,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [2:0]  reqOp,
  input  logic [1:0]  reqIdx,
  input  logic [3:0]  reqData,
  output logic        rspValid,
  output logic [3:0]  rspData,
  output logic        ramWe,
  output logic        ramRe,
  output logic [11:0] ramAddr,
  output logic [3:0]  ramDataIn,
  input  logic [3:0]  ramDataOut
`ifdef RAM_OUTPORT_EN
  ,
  output logic [15:0] outPort
`endif
);

  localparam int BANK_W = $clog2(NUM_BANKS);

  localparam logic [2:0] OP_WRM = 3'b000;
  localparam logic [2:0] OP_RDM = 3'b001;
  localparam logic [2:0] OP_WRS = 3'b010;
  localparam logic [2:0] OP_RDS = 3'b011;
`ifdef RAM_OUTPORT_EN
  localparam logic [2:0] OP_WMP = 3'b100;
`endif

  // The address layout and the capture stage are built for exactly this shape.
  generate
    if (NUM_BANKS != 8) begin : g_bad_banks
      $error("ram_access_ctrl: NUM_BANKS must be 8");
    end
    if (RD_LAT != 1) begin : g_bad_lat
      $error("ram_access_ctrl: only RD_LAT=1 is supported");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR     = 3'd1,
    S_RD_ISS = 3'd2,
    S_RD_CAP = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [7:0]        src_q;
  logic [BANK_W-1:0] bank_q;

  logic        we_nx, re_nx, rsp_v_nx;
  logic [11:0] addr_nx;
  logic [3:0]  din_nx, rsp_d_nx;
  logic [11:0] main_addr, stat_addr;
  logic        accept;

  assign reqReady  = (state == S_IDLE);
  assign accept    = reqValid && reqReady;
  assign main_addr = {1'b0, bank_q, src_q};
  assign stat_addr = {1'b1, bank_q, src_q[7:4], 2'b00, reqIdx};

  // SRC pointer and DCL bank; loads may arrive at any time and only affect
  // requests accepted after the load edge, since the address is latched at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q  <= '0;
      bank_q <= '0;
    end else begin
      if (srcLoad) src_q  <= srcAddr;
      if (dclLoad) bank_q <= dclBank;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state plus next values of the registered RAM/response outputs.
  always_comb begin
    state_nx = state;
    we_nx    = 1'b0;
    re_nx    = 1'b0;
    addr_nx  = '0;
    din_nx   = '0;
    rsp_v_nx = 1'b0;
    rsp_d_nx = rspData;
    case (state)
      S_IDLE: begin
        if (reqValid) begin
          case (reqOp)
            OP_WRM: begin
              state_nx = S_WR;
              we_nx    = 1'b1;
              addr_nx  = main_addr;
              din_nx   = reqData;
            end
            OP_WRS: begin
              state_nx = S_WR;
              we_nx    = 1'b1;
              addr_nx  = stat_addr;
              din_nx   = reqData;
            end
            OP_RDM: begin
              state_nx = S_RD_ISS;
              re_nx    = 1'b1;
              addr_nx  = main_addr;
            end
            OP_RDS: begin
              state_nx = S_RD_ISS;
              re_nx    = 1'b1;
              addr_nx  = stat_addr;
            end
            default: state_nx = S_DONE;
          endcase
        end
      end
      S_WR:     state_nx = S_IDLE;
      S_RD_ISS: state_nx = S_RD_CAP;
      S_RD_CAP: begin
        state_nx = S_IDLE;
        rsp_v_nx = 1'b1;
        rsp_d_nx = ramDataOut;
      end
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Registered RAM strobes, address/data and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ramWe     <= 1'b0;
      ramRe     <= 1'b0;
      ramAddr   <= '0;
      ramDataIn <= '0;
      rspValid  <= 1'b0;
      rspData   <= '0;
    end else begin
      ramWe     <= we_nx;
      ramRe     <= re_nx;
      ramAddr   <= addr_nx;
      ramDataIn <= din_nx;
      rspValid  <= rsp_v_nx;
      rspData   <= rsp_d_nx;
    end
  end

`ifdef RAM_OUTPORT_EN
  logic [3:0]        port_mem [NUM_BANKS][4];
  logic              wmp_pend;
  logic [BANK_W-1:0] wmp_bank;
  logic [1:0]        wmp_chip;
  logic [3:0]        wmp_data;

  // Latch the WMP target at accept so later pointer loads cannot redirect it,
  // then commit it at the edge that ends the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wmp_pend <= 1'b0;
      wmp_bank <= '0;
      wmp_chip <= '0;
      wmp_data <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int c = 0; c < 4; c++) port_mem[b][c] <= '0;
      end
    end else begin
      if (accept && (reqOp == OP_WMP)) begin
        wmp_pend <= 1'b1;
        wmp_bank <= bank_q;
        wmp_chip <= src_q[7:6];
        wmp_data <= reqData;
      end else if (state == S_DONE) begin
        wmp_pend <= 1'b0;
        if (wmp_pend) port_mem[wmp_bank][wmp_chip] <= wmp_data;
      end
    end
  end

  assign outPort = {port_mem[bank_q][3], port_mem[bank_q][2],
                    port_mem[bank_q][1], port_mem[bank_q][0]};
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
module tb_ram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        srcLoad, dclLoad, reqValid;
  logic [7:0]  srcAddr;
  logic [2:0]  dclBank, reqOp;
  logic [1:0]  reqIdx;
  logic [3:0]  reqData;
  logic        reqReady, rspValid, ramWe, ramRe;
  logic [3:0]  rspData, ramDataIn;
  logic [3:0]  ramDataOut = 4'h0;
  logic [11:0] ramAddr;
`ifdef RAM_OUTPORT_EN
  logic [15:0] outPort;
`endif

  always #5 clk = ~clk;

  ram_access_ctrl dut (
    .clk(clk), .rst(rst),
    .srcLoad(srcLoad), .srcAddr(srcAddr),
    .dclLoad(dclLoad), .dclBank(dclBank),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqOp(reqOp), .reqIdx(reqIdx), .reqData(reqData),
    .rspValid(rspValid), .rspData(rspData),
    .ramWe(ramWe), .ramRe(ramRe), .ramAddr(ramAddr),
    .ramDataIn(ramDataIn), .ramDataOut(ramDataOut)
`ifdef RAM_OUTPORT_EN
    , .outPort(outPort)
`endif
  );

  // Behavioural 4096x4 RAM with 1-cycle synchronous read.
  logic [3:0] mem [4096];
  always @(posedge clk) begin
    if (ramWe) mem[ramAddr] <= ramDataIn;
    if (ramRe) ramDataOut <= mem[ramAddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          we;
    bit          re;
    logic [11:0] addr;
    logic [3:0]  data;
    int          t;
  } acc_t;
  typedef struct {
    logic [3:0] data;
    int         t;
  } rsp_t;
  acc_t ram_q[$];
  rsp_t rsp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every RAM access and response must match the head of
  // its queue, including the cycle it was predicted for.
  always @(negedge clk) begin
    if (!rst) begin
      chk("we_re_both", 32'(ramWe & ramRe), 32'd0);
      if (ramWe || ramRe) begin
        if (ram_q.size() == 0) chk("unexpected_access", 32'({ramWe, ramRe}), 32'd0);
        else begin
          acc_t e;
          e = ram_q.pop_front();
          chk("acc_we", 32'(ramWe), 32'(e.we));
          chk("acc_re", 32'(ramRe), 32'(e.re));
          chk("acc_addr", 32'(ramAddr), 32'(e.addr));
          chk("acc_din", 32'(ramDataIn), e.we ? 32'(e.data) : 32'd0);
          chk("acc_cycle", 32'(cyc), 32'(e.t));
        end
      end else begin
        chk("idle_addr_din", 32'({ramAddr, ramDataIn}), 32'd0);
      end
      if (rspValid) begin
        if (rsp_q.size() == 0) chk("unexpected_rsp", 32'(rspValid), 32'd0);
        else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk("rsp_data", 32'(rspData), 32'(r.data));
          chk("rsp_cycle", 32'(cyc), 32'(r.t));
        end
      end
    end
  end

  task automatic load(input logic [2:0] d, input logic [7:0] s);
    @(negedge clk);
    dclBank = d; srcAddr = s; dclLoad = 1'b1; srcLoad = 1'b1;
    @(negedge clk);
    dclLoad = 1'b0; srcLoad = 1'b0;
  endtask

  // Present a request, wait (bounded) for acceptance, push expectations.
  // Returns at the negedge after the accept edge; t is the accept cycle.
  task automatic do_req(input logic [2:0] op, input logic [1:0] idx, input logic [3:0] data,
                        input logic [11:0] eaddr, input logic [3:0] erd, output int t);
    int n;
    acc_t a;
    rsp_t r;
    reqValid = 1'b1; reqOp = op; reqIdx = idx; reqData = data;
    n = 0;
    while (!reqReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    t = -1;
    if (!reqReady) chk("accept_timeout", 32'(reqReady), 32'd1);
    else begin
      t = cyc + 1;
      @(posedge clk);
      if (op == 3'b000 || op == 3'b010 || op == 3'b001 || op == 3'b011) begin
        a.we = (op == 3'b000 || op == 3'b010);
        a.re = !a.we;
        a.addr = eaddr; a.data = data; a.t = t;
        ram_q.push_back(a);
        if (a.re) begin
          r.data = erd; r.t = t + 2;
          rsp_q.push_back(r);
        end
      end
      @(negedge clk);
    end
    reqValid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  dcl;
    logic [7:0]  src;
    logic [1:0]  idx;
    logic [3:0]  data;
    logic [11:0] addr;
    logic [3:0]  rd;
  } vec_t;
  vec_t vt[13];

  initial begin
    int t1, t2;
    vt[0]  = '{3'b000, 3'd5, 8'hA7, 2'd0, 4'hC, 12'h5A7, 4'h0};
    vt[1]  = '{3'b001, 3'd5, 8'hA7, 2'd0, 4'h0, 12'h5A7, 4'hC};
    vt[2]  = '{3'b010, 3'd2, 8'h3F, 2'd2, 4'h9, 12'hA32, 4'h0};
    vt[3]  = '{3'b011, 3'd2, 8'h3F, 2'd2, 4'h0, 12'hA32, 4'h9};
    vt[4]  = '{3'b000, 3'd0, 8'h00, 2'd0, 4'h3, 12'h000, 4'h0};
    vt[5]  = '{3'b000, 3'd7, 8'hFF, 2'd0, 4'hF, 12'h7FF, 4'h0};
    vt[6]  = '{3'b001, 3'd7, 8'hFF, 2'd0, 4'h0, 12'h7FF, 4'hF};
    vt[7]  = '{3'b001, 3'd0, 8'h00, 2'd0, 4'h0, 12'h000, 4'h3};
    vt[8]  = '{3'b010, 3'd7, 8'hFF, 2'd3, 4'hA, 12'hFF3, 4'h0};
    vt[9]  = '{3'b011, 3'd7, 8'hFF, 2'd3, 4'h0, 12'hFF3, 4'hA};
    vt[10] = '{3'b001, 3'd5, 8'hA7, 2'd0, 4'h0, 12'h5A7, 4'hC};
    vt[11] = '{3'b101, 3'd1, 8'h12, 2'd1, 4'h7, 12'h000, 4'h0};
    vt[12] = '{3'b111, 3'd1, 8'h12, 2'd1, 4'h7, 12'h000, 4'h0};

    rst = 1'b1; srcLoad = 0; dclLoad = 0; reqValid = 0;
    srcAddr = 0; dclBank = 0; reqOp = 0; reqIdx = 0; reqData = 0;
    repeat (2) @(negedge clk);
    chk("rst_reqReady", 32'(reqReady), 32'd1);
    chk("rst_rspValid", 32'(rspValid), 32'd0);
    chk("rst_ramWe", 32'(ramWe), 32'd0);
    chk("rst_ramRe", 32'(ramRe), 32'd0);
    chk("rst_ramAddr", 32'(ramAddr), 32'd0);
    chk("rst_rspData", 32'(rspData), 32'd0);
`ifdef RAM_OUTPORT_EN
    chk("rst_outPort", 32'(outPort), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(reqReady), 32'd1);

    for (int i = 0; i < 13; i++) begin
      load(vt[i].dcl, vt[i].src);
      do_req(vt[i].op, vt[i].idx, vt[i].data, vt[i].addr, vt[i].rd, t1);
    end

    // Back-to-back reads with the request held: accepts 3 clocks apart.
    load(3'd5, 8'hA7);
    do_req(3'b001, 2'd0, 4'h0, 12'h5A7, 4'hC, t1);
    do_req(3'b001, 2'd0, 4'h0, 12'h5A7, 4'hC, t2);
    chk("rd_b2b_gap", 32'(t2 - t1), 32'd3);

    // Back-to-back writes: accepts 2 clocks apart; second value wins.
    load(3'd5, 8'hA8);
    do_req(3'b000, 2'd0, 4'h2, 12'h5A8, 4'h0, t1);
    do_req(3'b000, 2'd0, 4'h4, 12'h5A8, 4'h0, t2);
    chk("wr_b2b_gap", 32'(t2 - t1), 32'd2);
    do_req(3'b001, 2'd0, 4'h0, 12'h5A8, 4'h4, t1);

    // Illegal ops: DONE lasts one cycle.
    do_req(3'b110, 2'd0, 4'h1, 12'h000, 4'h0, t1);
    do_req(3'b101, 2'd0, 4'h1, 12'h000, 4'h0, t2);
    chk("illegal_gap", 32'(t2 - t1), 32'd2);

    // Pointer load in the accept cycle must not affect the in-flight read.
    load(3'd3, 8'h10);
    do_req(3'b000, 2'd0, 4'h5, 12'h310, 4'h0, t1);
    load(3'd3, 8'h20);
    do_req(3'b000, 2'd0, 4'h6, 12'h320, 4'h0, t1);
    load(3'd3, 8'h10);
    srcAddr = 8'h20; srcLoad = 1'b1;
    do_req(3'b001, 2'd0, 4'h0, 12'h310, 4'h5, t1);
    srcLoad = 1'b0;
    do_req(3'b001, 2'd0, 4'h0, 12'h320, 4'h6, t1);

    // Reset during RD_ISS: no response, stored data intact afterwards.
    load(3'd4, 8'hB2);
    do_req(3'b000, 2'd0, 4'hD, 12'h4B2, 4'h0, t1);
    do_req(3'b001, 2'd0, 4'h0, 12'h4B2, 4'hD, t1);
    chk("abort_in_rd_iss", 32'(ramRe), 32'd1);
    #2 rst = 1'b1;
    ram_q.delete();
    rsp_q.delete();
    #1;
    chk("abort_ramRe", 32'(ramRe), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_rspValid", 32'(rspValid), 32'd0);
      chk("abort_ramWe", 32'(ramWe), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(reqReady), 32'd1);
    load(3'd4, 8'hB2);
    do_req(3'b001, 2'd0, 4'h0, 12'h4B2, 4'hD, t1);

    // WMP: output port write, or accepted-and-dropped without the feature.
`ifdef RAM_OUTPORT_EN
    load(3'd1, 8'h80);
    do_req(3'b100, 2'd0, 4'h6, 12'h000, 4'h0, t1);
    @(negedge clk);
    chk("wmp_outPort", 32'(outPort), 32'h0600);
    load(3'd0, 8'h80);
    chk("wmp_bank0", 32'(outPort), 32'h0000);
    load(3'd1, 8'h00);
    chk("wmp_bank1_back", 32'(outPort), 32'h0600);
`else
    load(3'd1, 8'h80);
    do_req(3'b100, 2'd0, 4'h6, 12'h000, 4'h0, t1);
    do_req(3'b100, 2'd0, 4'h6, 12'h000, 4'h0, t2);
    chk("wmp_drop_gap", 32'(t2 - t1), 32'd2);
`endif

    repeat (6) @(negedge clk);
    chk("ram_q_drained", 32'(ram_q.size()), 32'd0);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
